async_fill_stream_checker: RTL and testbench
============================================

// Module: async_fill_stream_checker
// PURPOSE
//  Reader side of the ASYNC circ-buf-to-DDR3 path. Pops 132-bit tagged words (4-bit tag + 128-bit payload) from an FWFT FIFO
//  fed by DDR3 readback. Checks one fill's structure: waveform headers, data bursts, checksum, fill header.
//  Reports per-fill pass/fail, per-check error flags and counts to the status register block.
// PARAMETERS
//  TAG_WFM_HDR  4'h2  tag of waveform header word
//  TAG_DATA     4'h3  tag of ADC data burst word (8 samples)
//  TAG_CHKSUM   4'h4  tag of checksum word
//  TAG_FILL_HDR 4'h1  tag of fill header word; last word of every fill
// PORTS
//  adc_clk            in   1    single clock; all logic on rising edge
//  reset_clk_adc_n    in   1    synchronous, active-low reset
//  fifo_dat           in   132  FWFT FIFO head: [131:128] tag, [127:0] payload
//  fifo_empty         in   1    FIFO head invalid when high
//  fifo_rd_en         out  1    pop head; comb = !fifo_empty && state!=DONE
//  async_num_bursts   in   11   expected data bursts per waveform
//  initial_fill_num   in   24   expected fill number of first fill
//  initial_fill_num_wr in  1    load expected fill number (1-cycle strobe)
//  fill_done          out  1    1-cycle pulse after fill header consumed
//  fill_ok            out  1    valid with fill_done; 1 = no error flag set
//  err_flags          out  6    sticky per fill: [0]tag [1]wfm_num [2]wfm_adr [3]burst_cnt [4]checksum [5]fill_num/len
//  wfm_count          out  23   waveforms seen in current fill
//  fill_count         out  24   fills completed since reset (saturates at 24'hFFFFFF)
// BEHAVIOUR
//  Reset (reset_clk_adc_n==0 at edge): state=IDLE, outputs 0, word_adr=1, chk_acc=0, exp_fill_num unchanged.
//  Word consumed on edge where fifo_rd_en=1; no other handshake; one word per cycle max, zero added latency.
//  word_adr: 23-bit, =1 at fill start, +1 per consumed non-fill-header word (slot 0 reserved for fill header).
//  chk_acc: 128-bit XOR of payloads of every WFM_HDR and DATA word in the fill.
//  Waveform header payload: [22:0] waveform_num, [45:23] start_adr, [56:46] num_bursts.
//  Fill header payload: [23:0] fill_num, [46:24] num_fill_bursts (total words incl. fill header).
//  States:
//   IDLE     : WFM_HDR -> check, burst_left=async_num_bursts, WFM_DATA; CHKSUM -> check, FILL; else err[0], RESYNC.
//   WFM_DATA : DATA -> burst_left-1; at last burst -> IDLE. Any other tag before count done -> err[3], then handle as IDLE.
//   FILL     : FILL_HDR -> check, DONE; else err[0], RESYNC.
//   RESYNC   : discard words (no checks, no chk_acc) until a FILL_HDR is consumed -> DONE.
//   DONE     : one cycle; fill_done=1, fill_ok=(err_flags==0); clear word_adr=1, chk_acc=0, wfm_count=0,
//              err_flags cleared next cycle; exp_fill_num+1 (24-bit wrap); fill_count+1; -> IDLE. fifo_rd_en=0.
//  Checks: waveform_num==wfm_count else err[1]; start_adr==word_adr else err[2]; num_bursts==async_num_bursts else err[3];
//   checksum payload==chk_acc (value before checksum word) else err[4];
//   fill_num!=exp_fill_num or num_fill_bursts!=word_adr (at fill header) -> err[5].
//  wfm_count +1 on each WFM_HDR consumed (after its check).
//  async_num_bursts==0: WFM_HDR -> IDLE directly; zero-waveform fill (CHKSUM first) is legal.
//  initial_fill_num_wr: loads exp_fill_num; coincident with DONE increment -> load wins.
//  Mid-fill reset: all state discarded; bench must flush FIFO. No timeout: empty FIFO stalls in any state.
//  err_flags sticky from first error until DONE; hold valid through fill_done cycle.
// TESTING
//  T1 n=2, fill 5: W0 hdr(num0,adr1),2 DATA,W1 hdr(num1,adr4),2 DATA,CHKSUM ok,FILL(5,len8) -> fill_done, fill_ok=1, wfm_count=2.
//  T2 same stream, one DATA payload bit flipped after checksum computed -> fill_ok=0, err_flags=6'b010000.
//  T3 n=3, waveform with only 2 DATA then next WFM_HDR -> err[3] set, second header still checked, fill_ok=0.
//  T4 DATA tag in IDLE -> err[0], RESYNC drops words to next FILL_HDR, fill_done pulse, next fill passes cleanly.
//  T5 fifo_empty toggled randomly on T1 stream -> identical results; fifo_rd_en never high while empty.
//  T6 initial_fill_num=24'hFFFFFF, two valid fills numbered FFFFFF then 000000 -> both fill_ok=1.

Source files
------------

// File: rtl/async_fill_stream_checker.sv
// Pops tagged DDR3 readback words from an FWFT FIFO and checks one fill's framing and checksum.
// Consumes at most one word per cycle with no added latency; an empty FIFO stalls the checker in any state.
module async_fill_stream_checker #(
  parameter logic [3:0] TAG_WFM_HDR  = 4'h2,
  parameter logic [3:0] TAG_DATA     = 4'h3,
  parameter logic [3:0] TAG_CHKSUM   = 4'h4,
  parameter logic [3:0] TAG_FILL_HDR = 4'h1
) (
  input  logic         adc_clk,
  input  logic         reset_clk_adc_n,
  input  logic [131:0] fifo_dat,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [10:0]  async_num_bursts,
  input  logic [23:0]  initial_fill_num,
  input  logic         initial_fill_num_wr,
  output logic         fill_done,
  output logic         fill_ok,
  output logic [5:0]   err_flags,
  output logic [22:0]  wfm_count,
  output logic [23:0]  fill_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFM_DATA,
    S_FILL,
    S_RESYNC,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [22:0]    word_adr_q, word_adr_d;
  logic [127:0]   chk_acc_q, chk_acc_d;
  logic [22:0]    wfm_count_q, wfm_count_d;
  logic [5:0]     err_q, err_d;
  logic [10:0]    burst_left_q, burst_left_d;
  logic [23:0]    fill_count_q, fill_count_d;
  logic [23:0]    exp_fill_num_q, exp_fill_num_d;

  logic [3:0]     tag;
  logic [127:0]   pl;
  logic           idle_path;
  logic [5:0]     err_set;

  always_comb begin
    state_d        = state_q;
    word_adr_d     = word_adr_q;
    chk_acc_d      = chk_acc_q;
    wfm_count_d    = wfm_count_q;
    err_d          = err_q;
    burst_left_d   = burst_left_q;
    fill_count_d   = fill_count_q;
    exp_fill_num_d = exp_fill_num_q;
    err_set        = '0;
    idle_path      = 1'b0;
    tag            = fifo_dat[131:128];
    pl             = fifo_dat[127:0];

    fifo_rd_en = !fifo_empty && (state_q != S_DONE);
    fill_done  = (state_q == S_DONE);
    fill_ok    = fill_done && (err_q == 6'd0);

    if (state_q == S_DONE) begin
      state_d    = S_IDLE;
      word_adr_d = 23'd1;
      chk_acc_d  = '0;
      wfm_count_d = '0;
      err_d      = '0;
      if (fill_count_q != 24'hFFFFFF) fill_count_d = fill_count_q + 24'd1;
    end else if (fifo_rd_en) begin
      // Slot 0 of the fill belongs to the fill header, so it never advances the address.
      if (tag != TAG_FILL_HDR) word_adr_d = word_adr_q + 23'd1;

      case (state_q)
        S_IDLE: idle_path = 1'b1;
        S_WFM_DATA: begin
          if (tag == TAG_DATA) begin
            chk_acc_d = chk_acc_q ^ pl;
            if (burst_left_q <= 11'd1) state_d = S_IDLE;
            else                       burst_left_d = burst_left_q - 11'd1;
          end else begin
            // Short waveform: flag it, then treat the word as the start of the next item.
            err_set[3] = 1'b1;
            idle_path  = 1'b1;
          end
        end
        S_FILL: begin
          if (tag == TAG_FILL_HDR) begin
            if ((pl[23:0] != exp_fill_num_q) || (pl[46:24] != word_adr_q)) err_set[5] = 1'b1;
            state_d = S_DONE;
          end else begin
            err_set[0] = 1'b1;
            state_d    = S_RESYNC;
          end
        end
        S_RESYNC: begin
          if (tag == TAG_FILL_HDR) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase

      if (idle_path) begin
        if (tag == TAG_WFM_HDR) begin
          if (pl[22:0]  != wfm_count_q)      err_set[1] = 1'b1;
          if (pl[45:23] != word_adr_q)       err_set[2] = 1'b1;
          if (pl[56:46] != async_num_bursts) err_set[3] = 1'b1;
          chk_acc_d    = chk_acc_q ^ pl;
          wfm_count_d  = wfm_count_q + 23'd1;
          burst_left_d = async_num_bursts;
          state_d      = (async_num_bursts == 11'd0) ? S_IDLE : S_WFM_DATA;
        end else if (tag == TAG_CHKSUM) begin
          if (pl != chk_acc_q) err_set[4] = 1'b1;
          state_d = S_FILL;
        end else begin
          err_set[0] = 1'b1;
          state_d    = S_RESYNC;
        end
      end

      err_d = err_q | err_set;
    end

    // A software load in the same cycle as the end-of-fill increment takes priority.
    if ((state_q == S_DONE) && reset_clk_adc_n) exp_fill_num_d = exp_fill_num_q + 24'd1;
    if (initial_fill_num_wr) exp_fill_num_d = initial_fill_num;
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_clk_adc_n) begin
      state_q      <= S_IDLE;
      word_adr_q   <= 23'd1;
      chk_acc_q    <= '0;
      wfm_count_q  <= '0;
      err_q        <= '0;
      burst_left_q <= '0;
      fill_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_adr_q   <= word_adr_d;
      chk_acc_q    <= chk_acc_d;
      wfm_count_q  <= wfm_count_d;
      err_q        <= err_d;
      burst_left_q <= burst_left_d;
      fill_count_q <= fill_count_d;
    end
  end

  // Expected fill number survives reset so software programs it once.
  always_ff @(posedge adc_clk) begin
    exp_fill_num_q <= exp_fill_num_d;
  end

  assign err_flags  = err_q;
  assign wfm_count  = wfm_count_q;
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_async_fill_stream_checker.sv
// Randomized and directed fill streams checked against a word-list parser model of one fill.
module tb_async_fill_stream_checker;

  localparam logic [3:0] T_FILL = 4'h1;
  localparam logic [3:0] T_WFM  = 4'h2;
  localparam logic [3:0] T_DATA = 4'h3;
  localparam logic [3:0] T_CHK  = 4'h4;

  localparam int M_STRAY = 1;
  localparam int M_SHORT = 2;
  localparam int M_WNUM  = 4;
  localparam int M_FLIP  = 8;
  localparam int M_FNUM  = 16;
  localparam int M_LEN   = 32;

  logic         clk;
  logic         rst_n;
  logic [131:0] fifo_dat;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [10:0]  async_num_bursts;
  logic [23:0]  initial_fill_num;
  logic         initial_fill_num_wr;
  logic         fill_done;
  logic         fill_ok;
  logic [5:0]   err_flags;
  logic [22:0]  wfm_count;
  logic [23:0]  fill_count;

  int tests = 0;
  int fails = 0;
  int rd_bad = 0;
  int cnt_model = 0;
  logic [23:0] exp_num = 24'd0;

  logic [131:0] fw[$];
  logic [131:0] stream[$];
  logic [5:0]   exp_err[$];
  int           exp_wfm[$];
  logic [5:0]   r_err[$];
  logic         r_ok[$];
  int           r_wfm[$];
  logic [23:0]  r_cnt[$];

  async_fill_stream_checker dut (
    .adc_clk             (clk),
    .reset_clk_adc_n     (rst_n),
    .fifo_dat            (fifo_dat),
    .fifo_empty          (fifo_empty),
    .fifo_rd_en          (fifo_rd_en),
    .async_num_bursts    (async_num_bursts),
    .initial_fill_num    (initial_fill_num),
    .initial_fill_num_wr (initial_fill_num_wr),
    .fill_done           (fill_done),
    .fill_ok             (fill_ok),
    .err_flags           (err_flags),
    .wfm_count           (wfm_count),
    .fill_count          (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  always @(negedge clk) begin
    if (fill_done === 1'b1) begin
      r_err.push_back(err_flags);
      r_ok.push_back(fill_ok);
      r_wfm.push_back(int'(wfm_count));
      r_cnt.push_back(fill_count);
    end
    if (fifo_rd_en === 1'b1 && (fifo_empty === 1'b1 || fill_done === 1'b1)) rd_bad++;
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Builds one fill into fw; fields are derived from word positions, mask injects faults.
  task automatic build_fill(input int n, input int nw, input int mask);
    logic [127:0] acc, p;
    logic [23:0]  fn;
    int nb, flipped;
    fw.delete();
    acc = '0;
    if ((mask & M_STRAY) != 0) fw.push_back({T_DATA, rnd128()});
    for (int w = 0; w < nw; w++) begin
      p = rnd128();
      p[22:0] = 23'(w);
      if ((mask & M_WNUM) != 0 && w == nw - 1) p[22:0] = 23'(w + 3);
      p[45:23] = 23'(fw.size() + 1);
      p[56:46] = 11'(n);
      fw.push_back({T_WFM, p});
      acc ^= p;
      nb = ((mask & M_SHORT) != 0 && w == 0 && n > 0) ? n - 1 : n;
      for (int b = 0; b < nb; b++) begin
        p = rnd128();
        fw.push_back({T_DATA, p});
        acc ^= p;
      end
    end
    flipped = 0;
    if ((mask & M_FLIP) != 0) begin
      for (int i = 0; i < fw.size(); i++) begin
        if (flipped == 0 && fw[i][131:128] == T_DATA) begin
          fw[i][37] = ~fw[i][37];
          flipped = 1;
        end
      end
    end
    fw.push_back({T_CHK, acc});
    p = '0;
    fn = ((mask & M_FNUM) != 0) ? exp_num + 24'd7 : exp_num;
    p[23:0]  = fn;
    p[46:24] = ((mask & M_LEN) != 0) ? 23'(fw.size() + 2) : 23'(fw.size() + 1);
    fw.push_back({T_FILL, p});
  endtask

  // Parses the fill word list as the grammar: { WFM_HDR DATA^n } CHKSUM FILL_HDR.
  task automatic model_fill(input int n, input logic [23:0] expn,
                            output logic [5:0] err, output int wc);
    logic [127:0] acc, p;
    int i, k, fin;
    err = '0; acc = '0; wc = 0; i = 0; fin = 0;
    while (fin == 0 && i < fw.size()) begin
      p = fw[i][127:0];
      if (fw[i][131:128] == T_WFM) begin
        if (p[22:0]  != 23'(wc))    err[1] = 1'b1;
        if (p[45:23] != 23'(i + 1)) err[2] = 1'b1;
        if (p[56:46] != 11'(n))     err[3] = 1'b1;
        acc ^= p;
        wc++;
        i++;
        k = 0;
        while (k < n && i < fw.size() && fw[i][131:128] == T_DATA) begin
          acc ^= fw[i][127:0];
          i++;
          k++;
        end
        if (k < n) err[3] = 1'b1;
      end else if (fw[i][131:128] == T_CHK) begin
        if (p != acc) err[4] = 1'b1;
        i++;
        if (i < fw.size() && fw[i][131:128] == T_FILL) begin
          if (fw[i][23:0] != expn || fw[i][46:24] != 23'(i + 1)) err[5] = 1'b1;
        end else begin
          err[0] = 1'b1;
        end
        fin = 1;
      end else begin
        err[0] = 1'b1;
        fin = 1;
      end
    end
  endtask

  task automatic add_fill(input int n, input int nw, input int mask);
    logic [5:0] e;
    int wc;
    build_fill(n, nw, mask);
    model_fill(n, exp_num, e, wc);
    foreach (fw[i]) stream.push_back(fw[i]);
    exp_err.push_back(e);
    exp_wfm.push_back(wc);
    exp_num = exp_num + 24'd1;
    cnt_model++;
  endtask

  task automatic begin_test(input int n);
    stream.delete();
    exp_err.delete();
    exp_wfm.delete();
    async_num_bursts = 11'(n);
  endtask

  task automatic load_num(input logic [23:0] v);
    initial_fill_num    = v;
    initial_fill_num_wr = 1'b1;
    @(posedge clk); #1;
    initial_fill_num_wr = 1'b0;
    exp_num = v;
  endtask

  task automatic run_stream(input int empty_pct);
    int idx, guard;
    logic took;
    r_err.delete(); r_ok.delete(); r_wfm.delete(); r_cnt.delete();
    idx = 0;
    guard = 0;
    while (idx < stream.size() && guard < 20000) begin
      fifo_dat   = stream[idx];
      fifo_empty = (int'($urandom_range(0, 99)) < empty_pct);
      @(negedge clk);
      took = fifo_rd_en;
      @(posedge clk); #1;
      if (took) idx++;
      guard++;
    end
    fifo_empty = 1'b1;
    if (idx < stream.size()) begin
      tests++; fails++;
      $display("FAIL stream_timeout: consumed %0d of %0d words", idx, stream.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL reset_fill_done: got %b want 0", fill_done); end
    tests++; if (fill_ok !== 1'b0) begin fails++; $display("FAIL reset_fill_ok: got %b want 0", fill_ok); end
    tests++; if (err_flags !== 6'd0) begin fails++; $display("FAIL reset_err_flags: got %b want 000000", err_flags); end
    tests++; if (wfm_count !== 23'd0) begin fails++; $display("FAIL reset_wfm_count: got %0d want 0", wfm_count); end
    tests++; if (fill_count !== 24'd0) begin fails++; $display("FAIL reset_fill_count: got %0d want 0", fill_count); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en_empty: got %b want 0", fifo_rd_en); end
    fifo_empty = 1'b0;
    #1;
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL reset_rd_en_idle: got %b want 1", fifo_rd_en); end
    fifo_empty = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    begin_test(2);
    load_num(24'd5);
    add_fill(2, 2, 0);
    run_stream(0);
    tests++; if (r_ok.size() !== 1) begin fails++; $display("FAIL basic_fill_count: got %0d pulses want 1", r_ok.size()); end
    if (r_ok.size() >= 1) begin
      tests++; if (r_ok[0] !== 1'b1) begin fails++; $display("FAIL basic_fill_ok: got %b want 1", r_ok[0]); end
      tests++; if (r_err[0] !== 6'b000000) begin fails++; $display("FAIL basic_err: got %b want 000000", r_err[0]); end
      tests++; if (r_wfm[0] !== 2) begin fails++; $display("FAIL basic_wfm_count: got %0d want 2", r_wfm[0]); end
      tests++; if (r_cnt[0] !== 24'd0) begin fails++; $display("FAIL basic_cnt_at_done: got %0d want 0", r_cnt[0]); end
    end
    tests++; if (fill_count !== 24'(cnt_model)) begin fails++; $display("FAIL basic_fill_count_after: got %0d want %0d", fill_count, cnt_model); end
    tests++; if (err_flags !== 6'd0) begin fails++; $display("FAIL basic_err_cleared: got %b want 000000", err_flags); end
  endtask

  task automatic test_checksum_err();
    begin_test(2);
    add_fill(2, 2, M_FLIP);
    run_stream(0);
    tests++; if (r_ok.size() !== 1) begin fails++; $display("FAIL chk_fill_count: got %0d want 1", r_ok.size()); end
    if (r_ok.size() >= 1) begin
      tests++; if (r_err[0] !== 6'b010000) begin fails++; $display("FAIL chk_err: got %b want 010000", r_err[0]); end
      tests++; if (r_ok[0] !== 1'b0) begin fails++; $display("FAIL chk_fill_ok: got %b want 0", r_ok[0]); end
    end
  endtask

  task automatic test_short_burst();
    begin_test(3);
    add_fill(3, 2, M_SHORT);
    add_fill(3, 2, M_SHORT | M_WNUM);
    run_stream(0);
    tests++; if (r_ok.size() !== 2) begin fails++; $display("FAIL short_fill_count: got %0d want 2", r_ok.size()); end
    if (r_ok.size() >= 2) begin
      tests++; if (r_err[0] !== 6'b001000) begin fails++; $display("FAIL short_err: got %b want 001000", r_err[0]); end
      tests++; if (r_ok[0] !== 1'b0) begin fails++; $display("FAIL short_fill_ok: got %b want 0", r_ok[0]); end
      tests++; if (r_wfm[0] !== 2) begin fails++; $display("FAIL short_wfm_count: got %0d want 2", r_wfm[0]); end
      tests++; if (r_err[1] !== 6'b001010) begin fails++; $display("FAIL short_hdr_checked: got %b want 001010", r_err[1]); end
    end
  endtask

  task automatic test_resync();
    begin_test(2);
    add_fill(2, 2, M_STRAY);
    add_fill(2, 1, 0);
    run_stream(0);
    tests++; if (r_ok.size() !== 2) begin fails++; $display("FAIL resync_fill_count: got %0d want 2", r_ok.size()); end
    if (r_ok.size() >= 2) begin
      tests++; if (r_err[0] !== 6'b000001) begin fails++; $display("FAIL resync_err: got %b want 000001", r_err[0]); end
      tests++; if (r_ok[0] !== 1'b0) begin fails++; $display("FAIL resync_fill_ok: got %b want 0", r_ok[0]); end
      tests++; if (r_wfm[0] !== 0) begin fails++; $display("FAIL resync_wfm_count: got %0d want 0", r_wfm[0]); end
      tests++; if (r_err[1] !== 6'b000000) begin fails++; $display("FAIL resync_next_err: got %b want 000000", r_err[1]); end
      tests++; if (r_ok[1] !== 1'b1) begin fails++; $display("FAIL resync_next_ok: got %b want 1", r_ok[1]); end
    end
  endtask

  task automatic test_stall();
    begin_test(2);
    rd_bad = 0;
    add_fill(2, 2, 0);
    add_fill(2, 2, 0);
    run_stream(50);
    tests++; if (r_ok.size() !== 2) begin fails++; $display("FAIL stall_fill_count: got %0d want 2", r_ok.size()); end
    for (int k = 0; k < r_ok.size(); k++) begin
      tests++; if (r_ok[k] !== 1'b1 || r_err[k] !== 6'd0 || r_wfm[k] !== 2) begin
        fails++; $display("FAIL stall_fill%0d: got ok=%b err=%b wfm=%0d want ok=1 err=000000 wfm=2", k, r_ok[k], r_err[k], r_wfm[k]);
      end
    end
    tests++; if (rd_bad !== 0) begin fails++; $display("FAIL stall_rd_en_when_empty: got %0d cycles want 0", rd_bad); end
  endtask

  task automatic test_wrap();
    begin_test(2);
    load_num(24'hFFFFFF);
    add_fill(2, 2, 0);
    add_fill(2, 1, 0);
    run_stream(0);
    tests++; if (r_ok.size() !== 2) begin fails++; $display("FAIL wrap_fill_count: got %0d want 2", r_ok.size()); end
    if (r_ok.size() >= 2) begin
      tests++; if (r_ok[0] !== 1'b1) begin fails++; $display("FAIL wrap_fffff_ok: got %b err=%b want 1", r_ok[0], r_err[0]); end
      tests++; if (r_ok[1] !== 1'b1) begin fails++; $display("FAIL wrap_000000_ok: got %b err=%b want 1", r_ok[1], r_err[1]); end
    end
  endtask

  task automatic test_load_priority();
    int seen;
    begin_test(1);
    add_fill(1, 1, 0);
    exp_num = 24'h123456;
    add_fill(1, 1, 0);
    seen = 0;
    fork
      run_stream(0);
      begin
        for (int c = 0; c < 3000 && seen == 0; c++) begin
          @(negedge clk);
          if (fill_done === 1'b1) seen = 1;
        end
        if (seen != 0) begin
          initial_fill_num    = 24'h123456;
          initial_fill_num_wr = 1'b1;
          @(posedge clk); #1;
          initial_fill_num_wr = 1'b0;
        end
      end
    join
    tests++; if (seen == 0) begin fails++; $display("FAIL load_wait_done: no fill_done within budget"); end
    tests++; if (r_ok.size() !== 2) begin fails++; $display("FAIL load_fill_count: got %0d want 2", r_ok.size()); end
    if (r_ok.size() >= 2) begin
      tests++; if (r_ok[0] !== 1'b1) begin fails++; $display("FAIL load_first_ok: got %b err=%b want 1", r_ok[0], r_err[0]); end
      tests++; if (r_err[1] !== 6'd0) begin fails++; $display("FAIL load_wins_over_inc: got %b want 000000", r_err[1]); end
    end
  endtask

  task automatic test_random();
    int base, nw, mask, pct;
    for (int round = 0; round < 4; round++) begin
      begin_test(round);
      base = cnt_model;
      for (int f = 0; f < 6; f++) begin
        nw = int'($urandom_range(0, 3));
        mask = ($urandom_range(0, 1) == 0) ? 0 : (1 << $urandom_range(0, 5));
        if ($urandom_range(0, 5) == 0) mask = mask | (1 << $urandom_range(1, 5));
        add_fill(round, nw, mask);
      end
      pct = (round == 0) ? 0 : int'($urandom_range(10, 60));
      run_stream(pct);
      tests++; if (r_ok.size() !== exp_err.size()) begin
        fails++; $display("FAIL rand%0d_fill_count: got %0d want %0d", round, r_ok.size(), exp_err.size());
      end
      for (int k = 0; k < exp_err.size() && k < r_ok.size(); k++) begin
        tests++; if (r_err[k] !== exp_err[k]) begin fails++; $display("FAIL rand%0d_fill%0d_err: got %b want %b", round, k, r_err[k], exp_err[k]); end
        tests++; if (r_ok[k] !== (exp_err[k] == 6'd0)) begin fails++; $display("FAIL rand%0d_fill%0d_ok: got %b want %b", round, k, r_ok[k], exp_err[k] == 6'd0); end
        tests++; if (r_wfm[k] !== exp_wfm[k]) begin fails++; $display("FAIL rand%0d_fill%0d_wfm: got %0d want %0d", round, k, r_wfm[k], exp_wfm[k]); end
        tests++; if (r_cnt[k] !== 24'(base + k)) begin fails++; $display("FAIL rand%0d_fill%0d_cnt: got %0d want %0d", round, k, r_cnt[k], base + k); end
      end
    end
    tests++; if (fill_count !== 24'(cnt_model)) begin fails++; $display("FAIL rand_fill_count_total: got %0d want %0d", fill_count, cnt_model); end
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_dat = '0;
    fifo_empty = 1'b1;
    async_num_bursts = '0;
    initial_fill_num = '0;
    initial_fill_num_wr = 1'b0;
    test_reset();
    test_basic();
    test_checksum_err();
    test_short_burst();
    test_resync();
    test_stall();
    test_wrap();
    test_load_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
